// File: rtl/fir_pkg.sv
// Shared constants and types for the single-multiplier 16-tap FIR datapath.
package fir_pkg;

  localparam int TAPS          = 16;
  localparam int ADDR_W        = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_COEFF_W   = 16;
  localparam int DEF_ACC_W     = 36;
  localparam int DEF_OUT_W     = 16;
  localparam int DEF_OUT_SHIFT = 15;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/fir_round_sat.sv
// Accumulator to output conversion: round half up, arithmetic shift, clamp to
// the signed output range. Purely combinational.
module fir_round_sat #(
  parameter int ACC_W     = 36,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  // One extra bit so adding the rounding term can never wrap.
  localparam int EXT_W  = ACC_W + 1;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [EXT_W-1:0] ROUND =
    (OUT_SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
  localparam logic signed [EXT_W-1:0] MAX_V = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] shifted;

  // Round, shift, then clamp anything outside the output range.
  always_comb begin
    sum     = {acc_i[ACC_W-1], acc_i} + ROUND;
    shifted = sum >>> OUT_SHIFT;
    sat_o   = 1'b0;
    data_o  = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      data_o = MAX_V[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (shifted < MIN_V) begin
      data_o = MIN_V[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/single_macc_datapath.sv
// Arithmetic and storage half of the 16-tap single-multiplier FIR: sample and
// coefficient RAMs, read/multiply/accumulate pipeline and rounded output stage.
// Addresses and StartAcc/DataValid strobes come from the filter control block.
//
// Clear FSM:
//   state     | meaning
//   CLR_CLEAR | zeroing sample RAM, one word per cycle; sample writes and Valid_o blocked
//   CLR_RUN   | normal operation
module single_macc_datapath
  import fir_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEFF_W   = DEF_COEFF_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                      Clk_i,
  input  logic                      Rst_i,
  input  logic                      DataNd_i,
  input  logic signed [DATA_W-1:0]  Data_i,
  input  logic [ADDR_W-1:0]         DataAddrWr_i,
  input  logic [ADDR_W-1:0]         DataAddr_i,
  input  logic [ADDR_W-1:0]         CoeffAddr_i,
  input  logic                      StartAcc_i,
  input  logic                      DataValid_i,
  input  logic                      CoeffWe_i,
  input  logic [ADDR_W-1:0]         CoeffWrAddr_i,
  input  logic signed [COEFF_W-1:0] CoeffData_i,
  output logic                      ClrBusy_o,
  output logic signed [OUT_W-1:0]   Data_o,
  output logic                      Valid_o,
  output logic                      Sat_o
);

  localparam int PROD_W = DATA_W + COEFF_W;

  clr_state_e                state_q, state_d;
  logic [ADDR_W-1:0]         clr_cnt_q, clr_cnt_d;
  logic                      clr_we;
  logic                      run;

  logic signed [DATA_W-1:0]  sram_q [TAPS];
  logic signed [COEFF_W-1:0] cram_q [TAPS];

  logic signed [DATA_W-1:0]  data_rd_q;
  logic signed [COEFF_W-1:0] coeff_rd_q;
  logic signed [PROD_W-1:0]  data_ext, coeff_ext;
  logic signed [PROD_W-1:0]  prod_q;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  logic signed [OUT_W-1:0]   rs_data;
  logic                      rs_sat;
  logic signed [OUT_W-1:0]   data_q;
  logic                      valid_q, sat_q;

  // Clear FSM state and address counter.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q   <= CLR_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear FSM next state: walk addresses 0..TAPS-1 once, then run.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      CLR_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(TAPS - 1)) state_d = CLR_RUN;
      end
      CLR_RUN: ;
      default: state_d = CLR_CLEAR;
    endcase
  end

  assign run       = (state_q == CLR_RUN);
  assign ClrBusy_o = ~run;

  // Sample RAM write: clear has priority, new samples only accepted in run.
  always_ff @(posedge Clk_i) begin
    if (clr_we) begin
      sram_q[clr_cnt_q] <= '0;
    end else if (DataNd_i && run) begin
      sram_q[DataAddrWr_i] <= Data_i;
    end
  end

  // Coefficient RAM write; readers see the new value from the next edge.
  always_ff @(posedge Clk_i) begin
    if (CoeffWe_i) cram_q[CoeffWrAddr_i] <= CoeffData_i;
  end

  assign data_ext  = {{COEFF_W{data_rd_q[DATA_W-1]}}, data_rd_q};
  assign coeff_ext = {{DATA_W{coeff_rd_q[COEFF_W-1]}}, coeff_rd_q};
  assign prod_ext  = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign acc_d     = StartAcc_i ? prod_ext : acc_q + prod_ext;

  // Read, multiply and accumulate pipeline, one tap per cycle.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      data_rd_q  <= '0;
      coeff_rd_q <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      data_rd_q  <= sram_q[DataAddr_i];
      coeff_rd_q <= cram_q[CoeffAddr_i];
      prod_q     <= data_ext * coeff_ext;
      acc_q      <= acc_d;
    end
  end

  fir_round_sat #(
    .ACC_W     (ACC_W),
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc_i  (acc_q),
    .data_o (rs_data),
    .sat_o  (rs_sat)
  );

  // Output stage: capture the finished sum; Data_o/Sat_o hold between pulses.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= DataValid_i && run;
      if (DataValid_i && run) begin
        data_q <= rs_data;
        sat_q  <= rs_sat;
      end
    end
  end

  assign Data_o  = data_q;
  assign Valid_o = valid_q;
  assign Sat_o   = sat_q;

endmodule

// File: doc/single_macc_datapath.md
Name: single_macc_datapath

Overview:
Arithmetic and storage half of the 16-tap single-multiplier FIR. It holds the 16-entry circular sample RAM and the 16-entry coefficient RAM, and consumes the write/read/coefficient addresses, StartAcc and DataValid strobes produced by the filter control block. Per input sample it performs one multiply-accumulate per cycle and emits one rounded, saturated output sample. A post-reset clear sequencer zeroes the sample RAM so the first outputs see zero history.

Parameters:
DATA_W, 16, signed input sample width
COEFF_W, 16, signed coefficient width
ACC_W, 36, accumulator width (DATA_W+COEFF_W+4 guard bits; must be >= that)
OUT_W, 16, signed output width
OUT_SHIFT, 15, right shift applied to the accumulator before rounding/saturation

Ports:
Clk_i  in  1  clock
Rst_i  in  1  reset
DataNd_i  in  1  new input sample strobe, single cycle
Data_i  in  DATA_W  input sample, qualified by DataNd_i
DataAddrWr_i  in  4  sample RAM write address from control
DataAddr_i  in  4  sample RAM read address from control
CoeffAddr_i  in  4  coefficient RAM read address from control
StartAcc_i  in  1  accumulator load strobe from control
DataValid_i  in  1  accumulation-complete strobe from control
CoeffWe_i  in  1  coefficient write enable
CoeffWrAddr_i  in  4  coefficient write address
CoeffData_i  in  COEFF_W  coefficient write data
ClrBusy_o  out  1  sample-RAM clear in progress
Data_o  out  OUT_W  filter output
Valid_o  out  1  Data_o valid, single-cycle pulse
Sat_o  out  1  Data_o was saturated, qualified by Valid_o

Behaviour:
- Reset is Rst_i, asynchronous, active-high. Clock is Clk_i.
- Reset values: Data_o=0, Valid_o=0, Sat_o=0, ClrBusy_o=1. All pipeline registers and the accumulator are 0. Clear counter is 0. RAM contents are not reset.
- Clear FSM, states CLEAR and RUN:
  - Reset enters CLEAR.
  - In CLEAR, one sample RAM word per cycle is written with 0, at the counter address 0..15. After address 15 the FSM goes to RUN and ClrBusy_o drops on the following cycle, i.e. 16 cycles of ClrBusy_o after reset release.
  - In CLEAR, DataNd_i sample writes are suppressed, and Valid_o is forced to 0.
  - Rst_i asserted mid-clear restarts the clear at address 0.
- Sample write (RUN only): on an edge with DataNd_i=1, RAM[DataAddrWr_i] <= Data_i.
- Timing, with edge E0 being the edge where DataNd_i is sampled high:
  - Cycle k (between E_k and E_k+1), k=0..15: control presents tap-k addresses.
  - E_k+1: synchronous read of both RAMs into registers. The tap-0 read at E1 returns the sample written at E0 (write-before-read across edges; no bypass needed).
  - E_k+2: signed full-precision product registered (DATA_W+COEFF_W bits).
  - E_k+3: accumulator updates. If StartAcc_i=1 then acc <= sign-extended product, else acc <= acc + product. StartAcc_i is high in cycle 2, aligned with the tap-0 product.
  - DataValid_i is high in cycle 18, when acc holds the full 16-tap sum.
  - E19: output stage registers Data_o, Valid_o=1 and Sat_o. Latency is 19 cycles from the DataNd_i edge to Valid_o.
- Output arithmetic:
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, arithmetic shift, round half up. No rounding term when OUT_SHIFT=0.
  - If r is outside the signed OUT_W range, clamp to max/min and set Sat_o=1.
  - Data_o holds its value between Valid_o pulses.
- Coefficient write: on an edge with CoeffWe_i=1, CRAM[CoeffWrAddr_i] <= CoeffData_i. The new value is visible to reads from the next edge onward. Writes during a computation are permitted and affect only taps read afterwards.
- Accumulator wrap: cannot occur within 16 taps at the default widths. No overflow detection on acc.
- DataNd_i arriving before the previous sample's DataValid_i: the new StartAcc_i reloads acc, so the previous result is abandoned. Control never raises DataValid_i for an aborted sample, so no Valid_o pulse is produced for it.
- Address wrap is modulo 16 inherently; 4-bit addresses.

Decomposition:
- Shared package fir_pkg: TAPS=16, ADDR_W=4, default DATA_W/COEFF_W/ACC_W/OUT_W/OUT_SHIFT, and the clear-FSM state enum.
- One natural sub-module: fir_round_sat (combinational rounding, shift and saturation, with OUT_SHIFT and widths as parameters). It is instantiated in front of the output register.

Test Plan:
- Reset release -> ClrBusy_o high for exactly 16 cycles. A DataNd_i pulse inside that window writes nothing and gives no Valid_o.
- Bench params OUT_SHIFT=0, OUT_W=32; coeffs c[k]=k+1; impulse 1 then fifteen 0s -> Valid_o 19 cycles after each DataNd_i, Data_o = 1,2,...,16, then 0. Sat_o=0 throughout.
- Same params, all coeffs 1, constant input 100 -> outputs 100,200,...,1600, then steady 1600.
- Default params, all coeffs 0x7FFF, input 0x7FFF repeated -> Data_o saturates to 0x7FFF with Sat_o=1. Input 0x8000 with coeffs 0x7FFF -> Data_o=0x8000, Sat_o=1.
- Rounding: OUT_SHIFT=15, single tap c0=1, other coeffs 0, input 0x4000 -> Data_o=1 (0.5 rounds up). Input 0x3FFF -> Data_o=0.
- DataNd_i reissued 8 cycles after the previous one -> exactly one Valid_o, 19 cycles after the second strobe. Rewriting c[15] during cycle 5 of a computation -> that computation uses the new c[15].
